fpu_norm_round: RTL and testbench
=================================

FPU_NORM_ROUND -- requirements
Module: fpu_norm_round

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 SHALL expose ports, in this order:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  load request, sampled in IDLE only
- sign_in  input  1  result sign
- e_in  input  10  signed unbiased exponent
- m_in  input  28  unsigned mantissa: bit27 carry, bit26 hidden one, bits25..3 fraction, bit2 guard, bit1 round, bit0 sticky
- result  output  32  IEEE-754 single result, held until next completion
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse

Function
REQ-003 SHALL implement the state machine IDLE -> NORM -> ROUND -> PACK -> IDLE, one transition per clock.
REQ-004 IDLE: when start=1, SHALL capture sign_in, e_in and m_in into internal registers and go to NORM; start SHALL be ignored in every other state.
REQ-005 NORM: if m==0, SHALL go directly to PACK.
REQ-006 NORM: else if m[27]==1 or e < -126 (signed), SHALL set m <= m>>1 with new m[0] = old m[1] | old m[0], set e <= e+1, and stay in NORM.
REQ-007 NORM: else if m[26]==0 and e > -126, SHALL set m <= m<<1, set e <= e-1, and stay in NORM.
REQ-008 NORM: otherwise SHALL go to ROUND; each NORM step costs exactly one cycle.
REQ-009 ROUND: SHALL round to nearest even with guard=m[2], rs=m[1]|m[0], lsb=m[3]; if guard & (rs | lsb), SHALL set m <= m + 8; SHALL then go to PACK.
REQ-010 PACK: if m[27]==1 (rounding carry), SHALL shift right by one and increment e before encoding; this SHALL be combinational within the PACK cycle.
REQ-011 PACK encoding, first matching rule applies:
- m==0 -> {sign, 31'b0}
- e > 127 -> {sign, 8'hFF, 23'b0}, overflow to infinity
- m[26]==0 -> {sign, 8'h00, m[25:3]}, denormal
- otherwise -> {sign, e+127, m[25:3]}
REQ-012 PACK: SHALL register result, assert done for exactly one cycle, and return to IDLE.
REQ-013 SHALL have a latency from the start edge to done=1 of 4 cycles plus one per NORM shift; a zero mantissa SHALL take 3 cycles.
REQ-014 SHALL keep the exponent arithmetic 10-bit signed with no wrap for inputs in [-200, 200].
REQ-015 SHALL accept start on the cycle after done.

Reset
REQ-016 With rst=1 SHALL set state to IDLE and result, done and busy to 0; internal m, e and sign SHALL be don't-care.
REQ-017 rst during NORM, ROUND or PACK SHALL abort the operation with no done pulse; rst SHALL take priority over start.

Structure
REQ-018 A shared fpu package SHALL hold the state encoding, the bias constant 127, EMIN=-126, EMAX=127 and the mantissa field bit positions (hidden=26, carry=27, guard=2), common with the alignment stage.
REQ-019 One sub-module, fpu_round_rne (combinational guard/lsb decision plus increment), is natural; everything else SHALL stay inline.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- sign=0, e=0, m=0x4000000 -> result 0x3F800000; done 4 cycles after start.
- e=0, m=0x8000000 -> 0x40000000 after 5 cycles (one right shift).
- e=0, m=0x0000040 -> 20 left shifts, result 0x35800000 after 24 cycles.
- e=0, m=0x7FFFFFC -> round-up carry, result 0x40000000; e=0, m=0x4000004 (tie, even) -> 0x3F800000.
- sign=1, m=0 -> 0x80000000 after 3 cycles; e=128, m=0x4000000 -> 0x7F800000.
- rst asserted mid-NORM on the cancellation case -> busy=0 next cycle, no done pulse, result=0; start applied while busy -> ignored, first result unchanged.

Source files
------------

// File: rtl/fpu_norm_round_pkg.sv
// fpu_norm_round_pkg
//   Shared definitions for the FPU back end: controller state encoding,
//   IEEE-754 single-precision exponent limits and the bit positions of the
//   fields inside the 28-bit working mantissa. The alignment stage uses the
//   same mantissa layout, so these constants live here rather than in any
//   one module.
//
//   Working mantissa layout (28 bits):
//     [27]    carry out of an add or a rounding increment
//     [26]    hidden one
//     [25:3]  23-bit fraction
//     [2]     guard
//     [1]     round
//     [0]     sticky
package fpu_norm_round_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        PACK  = 2'd3
    } state_t;

    localparam int M_W = 28;
    localparam int E_W = 10;

    localparam int CARRY_BIT  = 27;
    localparam int HIDDEN_BIT = 26;
    localparam int LSB_BIT    = 3;
    localparam int GUARD_BIT  = 2;
    localparam int ROUND_BIT  = 1;
    localparam int STICKY_BIT = 0;

    localparam logic signed [E_W-1:0] BIAS = 10'sd127;
    localparam logic signed [E_W-1:0] EMIN = -10'sd126;
    localparam logic signed [E_W-1:0] EMAX = 10'sd127;

endpackage

// File: rtl/fpu_norm_round_rne.sv
// fpu_round_rne
//   Combinational round-to-nearest-even on the working mantissa. Adds one
//   unit in the last place (bit 3) when the discarded part is above half an
//   ulp, or exactly half and the kept part is odd.
//
//   Ports:
//     m          in   28  normalised mantissa with guard/round/sticky bits
//     m_rounded  out  28  mantissa after the optional increment; a carry
//                         into bit 27 is left for the caller to handle
module fpu_round_rne
    import fpu_norm_round_pkg::*;
(
    input  logic [M_W-1:0] m,
    output logic [M_W-1:0] m_rounded
);

    localparam logic [M_W-1:0] ULP = M_W'(1) << LSB_BIT;

    logic guard;
    logic rs;
    logic lsb;
    logic round_up;

    assign guard = m[GUARD_BIT];
    assign rs    = m[ROUND_BIT] | m[STICKY_BIT];
    assign lsb   = m[LSB_BIT];

    // Ties (guard set, nothing below it) only round up when that makes the
    // result even.
    assign round_up  = guard & (rs | lsb);
    assign m_rounded = round_up ? (m + ULP) : m;

endmodule

// File: rtl/fpu_norm_round.sv
// fpu_norm_round
//   Multi-cycle normalise / round / pack stage producing an IEEE-754 single
//   from a sign, a 10-bit signed unbiased exponent and a 28-bit working
//   mantissa. Normalisation moves one bit per clock, so latency depends on
//   how far the mantissa is from the hidden-one position.
//
//   Ports:
//     clk      in   1   clock
//     rst      in   1   synchronous active-high reset
//     start    in   1   load request, only looked at while idle
//     sign_in  in   1   result sign
//     e_in     in   10  signed unbiased exponent
//     m_in     in   28  working mantissa (carry, hidden, fraction, G, R, S)
//     result   out  32  packed single, held until the next completion
//     busy     out  1   high while an operation is in flight
//     done     out  1   one-cycle pulse when result is updated
module fpu_norm_round
    import fpu_norm_round_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sign_in,
    input  logic [E_W-1:0]        e_in,
    input  logic [M_W-1:0]        m_in,
    output logic [31:0]           result,
    output logic                  busy,
    output logic                  done
);

    state_t                state;
    state_t                state_next;
    logic                  sgn;
    logic                  sgn_next;
    logic signed [E_W-1:0] expo;
    logic signed [E_W-1:0] expo_next;
    logic [M_W-1:0]        mant;
    logic [M_W-1:0]        mant_next;
    logic [31:0]           result_next;
    logic                  done_next;

    logic [M_W-1:0]        mant_rounded;
    logic [M_W-1:0]        mant_pack;
    logic signed [E_W-1:0] expo_pack;
    logic [7:0]            exp_field;
    logic [31:0]           packed_word;

    fpu_round_rne u_round (
        .m         (mant),
        .m_rounded (mant_rounded)
    );

    // A rounding carry can only push the mantissa to exactly 2.0, so the
    // bit dropped by this shift is always zero and no sticky is needed.
    assign mant_pack = mant[CARRY_BIT] ? (mant >> 1) : mant;
    assign expo_pack = mant[CARRY_BIT] ? (expo + 10'sd1) : expo;
    assign exp_field = 8'(expo_pack + BIAS);

    assign busy = (state != IDLE);

    // Final encoding. A mantissa without the hidden one can only remain
    // when the exponent stopped at EMIN, so it is a denormal with a zero
    // exponent field.
    always_comb begin
        packed_word = {sgn, exp_field, mant_pack[HIDDEN_BIT-1:LSB_BIT]};
        if (mant_pack == '0) begin
            packed_word = {sgn, 31'b0};
        end else if (expo_pack > EMAX) begin
            packed_word = {sgn, 8'hFF, 23'b0};
        end else if (!mant_pack[HIDDEN_BIT]) begin
            packed_word = {sgn, 8'h00, mant_pack[HIDDEN_BIT-1:LSB_BIT]};
        end
    end

    // Next-state and datapath decisions. Normalisation shifts right while
    // there is a carry or the exponent is below the denormal floor, and
    // shifts left while the hidden one is missing and there is exponent
    // room. Right shifts fold the lost bit into sticky.
    always_comb begin
        state_next  = state;
        sgn_next    = sgn;
        expo_next   = expo;
        mant_next   = mant;
        result_next = result;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sgn_next   = sign_in;
                    expo_next  = e_in;
                    mant_next  = m_in;
                    state_next = NORM;
                end
            end
            NORM: begin
                if (mant == '0) begin
                    state_next = PACK;
                end else if (mant[CARRY_BIT] || (expo < EMIN)) begin
                    mant_next = {1'b0, mant[M_W-1:2], mant[ROUND_BIT] | mant[STICKY_BIT]};
                    expo_next = expo + 10'sd1;
                end else if (!mant[HIDDEN_BIT] && (expo > EMIN)) begin
                    mant_next = mant << 1;
                    expo_next = expo - 10'sd1;
                end else begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                mant_next  = mant_rounded;
                state_next = PACK;
            end
            PACK: begin
                result_next = packed_word;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            result <= result_next;
            done   <= done_next;
        end
    end

    // Operand registers carry no reset; they are reloaded on every start.
    always_ff @(posedge clk) begin
        sgn  <= sgn_next;
        expo <= expo_next;
        mant <= mant_next;
    end

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round
//   Self-checking bench for fpu_norm_round: a table of directed vectors,
//   hand-written reset-abort and start-while-busy sequences, and random
//   operands checked against an exact-arithmetic rounding model.
module tb_fpu_norm_round;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign_in;
    logic [9:0]  e_in;
    logic [27:0] m_in;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    typedef struct {
        string       name;
        logic        sign;
        int          e;
        logic [27:0] m;
        logic [31:0] exp_result;
        int          exp_latency;
    } vec_t;

    vec_t table_v[7];

    fpu_norm_round dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sign_in (sign_in),
        .e_in    (e_in),
        .m_in    (m_in),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Launch one operation and wait (bounded) for done. Latency counts the
    // clock edges from the one that samples start up to the one that raises
    // done, both included.
    task automatic applyStimulus(input logic s, input int e, input logic [27:0] m,
                                 output logic [31:0] res, output int lat);
        @(negedge clk);
        sign_in = s;
        e_in    = 10'(e);
        m_in    = m;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (1) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
            if (lat > 200) break;
        end
        res = result;
    endtask

    // Exact rounding of m * 2^(e-26) to single precision, done on integers.
    function automatic logic [31:0] ref_result(input logic s, input int e, input logic [27:0] m);
        int p;
        int ee;
        int sh;
        int k;
        int biased;
        longint unsigned mm;
        longint unsigned q;
        longint unsigned r;
        longint unsigned half;
        logic [31:0] bw;
        if (m == 28'd0) return {s, 31'b0};
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        ee = e - 26 + p;
        if (ee < -126) ee = -126;
        sh = e - 3 - ee;
        mm = longint'(m);
        if (sh >= 0) begin
            q = mm << sh;
            r = 0;
            half = 1;
        end else begin
            k = -sh;
            if (k > 60) k = 60;
            q = mm >> k;
            r = mm - (q << k);
            half = longint'(1) << (k - 1);
        end
        if ((r > half) || ((r == half) && q[0])) q = q + 1;
        if (q >= (longint'(1) << 24)) begin
            q = q >> 1;
            ee = ee + 1;
        end
        if (ee > 127) return {s, 8'hFF, 23'b0};
        biased = (q >= (longint'(1) << 23)) ? ee + 127 : 0;
        bw = 32'(biased);
        return {s, bw[7:0], q[22:0]};
    endfunction

    // One cycle per exponent step taken to reach the normalised exponent
    // (never below -126), plus the fixed load/round/pack overhead.
    function automatic int ref_latency(input int e, input logic [27:0] m);
        int p;
        int ef;
        if (m == 28'd0) return 3;
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        ef = e - 26 + p;
        if (ef < -126) ef = -126;
        return 4 + ((ef > e) ? (ef - e) : (e - ef));
    endfunction

    initial begin
        logic [31:0] res;
        int          lat;
        logic        seen_done;
        logic        s;
        int          e;
        logic [27:0] m;
        int          sel;

        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        start   = 1'b0;
        sign_in = 1'b0;
        e_in    = '0;
        m_in    = '0;

        table_v[0] = '{"one",          1'b0,   0, 28'h4000000, 32'h3F800000,  4};
        table_v[1] = '{"carry shift",  1'b0,   0, 28'h8000000, 32'h40000000,  5};
        table_v[2] = '{"cancel 20",    1'b0,   0, 28'h0000040, 32'h35800000, 24};
        table_v[3] = '{"round carry",  1'b0,   0, 28'h7FFFFFC, 32'h40000000,  4};
        table_v[4] = '{"tie even",     1'b0,   0, 28'h4000004, 32'h3F800000,  4};
        table_v[5] = '{"neg zero",     1'b1,   0, 28'h0000000, 32'h80000000,  3};
        table_v[6] = '{"overflow inf", 1'b0, 128, 28'h4000000, 32'h7F800000,  4};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset result", result, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        checkOutput("reset done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(table_v[i].sign, table_v[i].e, table_v[i].m, res, lat);
            checkOutput({table_v[i].name, " result"}, res, table_v[i].exp_result);
            checkOutput({table_v[i].name, " latency"}, 32'(lat), 32'(table_v[i].exp_latency));
            checkOutput({table_v[i].name, " busy at done"}, {31'b0, busy}, 32'h0);
            @(posedge clk);
            #1 checkOutput({table_v[i].name, " done width"}, {31'b0, done}, 32'h0);
        end

        // Start held high while busy must not disturb the running operation.
        @(negedge clk);
        sign_in = 1'b0;
        e_in    = 10'd0;
        m_in    = 28'h0000040;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sign_in = 1'b1;
        e_in    = 10'd5;
        m_in    = 28'h4000000;
        lat = 1;
        seen_done = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 6) checkOutput("busy mid op", {31'b0, busy}, 32'h1);
            if (lat == 12) start = 1'b0;
            if (done) seen_done = 1'b1;
        end
        checkOutput("busy start result", result, 32'h35800000);
        checkOutput("busy start latency", 32'(lat), 32'd24);
        @(posedge clk);
        #1 checkOutput("idle after ignored start", {31'b0, busy}, 32'h0);

        // Reset mid-normalisation, with start also high, aborts cleanly.
        @(negedge clk);
        sign_in = 1'b0;
        e_in    = 10'd0;
        m_in    = 28'h0000040;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort busy", {31'b0, busy}, 32'h0);
        checkOutput("abort done", {31'b0, done}, 32'h0);
        checkOutput("abort result", result, 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1 if (done || busy) seen_done = 1'b1;
        end
        checkOutput("no activity after abort", {31'b0, seen_done}, 32'h0);
        checkOutput("result after abort", result, 32'h0);

        // Random operands, issued back to back.
        for (int n = 0; n < 300; n++) begin
            s   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 6) e = int'($urandom_range(0, 280)) - 140;
            else         e = int'($urandom_range(0, 400)) - 200;
            m = 28'($urandom()) >> $urandom_range(0, 27);
            if (sel == 9) m = 28'd0;
            applyStimulus(s, e, m, res, lat);
            checkOutput($sformatf("rand %0d result (e=%0d m=%h)", n, e, m), res, ref_result(s, e, m));
            checkOutput($sformatf("rand %0d latency", n), 32'(lat), 32'(ref_latency(e, m)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
